// File: rtl/lab2v2_io_pkg.sv
// Shared constants and helpers for the lab2v2 board I/O path (switch/button debouncing).
package lab2v2_io_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
    localparam int unsigned IO_WIDTH                = 10;

    // Channel state is not stored: it is the s2-vs-output comparison.
    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } chan_state_e;

    // Stability counter width; must hold DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(DEBOUNCE_CYCLES_DEFAULT);

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchronizer, stability counter, registered output and change strobe.
module debounce_channel
    import lab2v2_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic debounced_out,
    output logic change_pulse
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             pulse_q;
    logic             pulse_d;
    chan_state_e      state_c;

    // State register, synchronizer and output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            out_q   <= RESET_VALUE;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= raw_in;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_c = (s2_q == out_q) ? CH_STABLE : CH_PENDING;
    end

    // Any return to STABLE clears the counter, so a bounce restarts the window.
    always_comb begin
        cnt_d   = '0;
        out_d   = out_q;
        pulse_d = 1'b0;
        case (state_c)
            CH_PENDING: begin
                if (cnt_q == CNT_LAST) begin
                    out_d   = s2_q;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign debounced_out = out_q;
    assign change_pulse  = pulse_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous switch/button pins ahead of the input PIO; channels are fully independent.
module switch_debouncer
    import lab2v2_io_pkg::*;
#(
    parameter int unsigned      WIDTH           = IO_WIDTH,
    parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] change_pulse
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[g])
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .raw_in        (raw_in[g]),
            .debounced_out (debounced_out[g]),
            .change_pulse  (change_pulse[g])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus randomized runs against a window model.
module tb_switch_debouncer;
    import lab2v2_io_pkg::*;

    localparam int unsigned      W  = 10;
    localparam int unsigned      N  = DEBOUNCE_CYCLES_SIM;
    localparam logic [W-1:0]     RV = '0;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] debounced_out;
    logic [W-1:0] change_pulse;

    int checks   = 0;
    int failures = 0;

    // Model: raw samples per edge; an output bit flips once the N samples
    // visible to the comparator (2 edges of sync delay) all disagree with it.
    logic [W-1:0] hist [0:N];
    logic [W-1:0] m_out;
    logic [W-1:0] m_pulse;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N),
        .RESET_VALUE     (RV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .debounced_out (debounced_out),
        .change_pulse  (change_pulse)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int j = 0; j <= int'(N); j++) hist[j] = '0;
        m_out   = RV;
        m_pulse = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] r);
        for (int i = 0; i < int'(W); i++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= int'(N); j++)
                if (hist[j][i] == m_out[i]) all_diff = 1'b0;
            m_pulse[i] = all_diff;
            if (all_diff) m_out[i] = ~m_out[i];
        end
        for (int j = int'(N); j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = r;
    endtask

    // Raw changes 1 time unit after an edge; outputs are sampled at the same point.
    task automatic drive_edge(input logic [W-1:0] r);
        raw_in = r;
        @(posedge clk);
        #1;
        model_edge(r);
    endtask

    task automatic test_reset();
        int pulse_at;
        raw_in = '1;
        reset  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (debounced_out !== RV || change_pulse !== '0) begin
            failures++;
            $display("FAIL reset_hold: out=%h pulse=%h expected out=%h pulse=000", debounced_out, change_pulse, RV);
        end
        reset = 1'b0;
        checks++;
        if (debounced_out !== RV) begin
            failures++;
            $display("FAIL reset_release: out=%h expected %h", debounced_out, RV);
        end
        pulse_at = -1;
        for (int e = 0; e < 10; e++) begin
            drive_edge('1);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL reset_seq e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse === 10'h3FF && pulse_at < 0) pulse_at = e;
        end
        checks++;
        if (pulse_at != 5) begin
            failures++;
            $display("FAIL reset_latency: full-width pulse at edge %0d expected 5", pulse_at);
        end
    endtask

    task automatic test_single_press();
        int pulse_at;
        for (int e = 0; e < 10; e++) begin
            drive_edge('0);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL press_settle e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
        end
        pulse_at = -1;
        for (int e = 0; e < 10; e++) begin
            drive_edge(10'h001);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL press e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[0] === 1'b1 && pulse_at < 0) pulse_at = e;
        end
        checks++;
        if (pulse_at != 5 || debounced_out !== 10'h001 || change_pulse !== 10'h000) begin
            failures++;
            $display("FAIL press_latency: pulse edge=%0d out=%h pulse=%h expected edge 5 out=001 pulse=000", pulse_at, debounced_out, change_pulse);
        end
    endtask

    task automatic test_glitch();
        logic saw_pulse;
        logic rose;
        for (int e = 0; e < 10; e++) drive_edge('0);
        m_out = debounced_out === '0 ? m_out : m_out; // outputs checked below, settle only
        saw_pulse = 1'b0;
        for (int e = 0; e < 13; e++) begin
            drive_edge(e < 3 ? 10'h008 : 10'h000);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL glitch3 e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[3] !== 1'b0 || debounced_out[3] !== 1'b0) saw_pulse = 1'b1;
        end
        checks++;
        if (saw_pulse) begin
            failures++;
            $display("FAIL glitch3_reject: bit3 changed or pulsed, required to stay 0");
        end
        rose = 1'b0;
        for (int e = 0; e < 14; e++) begin
            drive_edge(e < 4 ? 10'h008 : 10'h000);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL glitch4 e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (debounced_out[3] === 1'b1) rose = 1'b1;
        end
        checks++;
        if (!rose) begin
            failures++;
            $display("FAIL glitch4_accept: bit3 never rose, required to rise");
        end
    endtask

    task automatic test_bounce();
        logic seq [0:6];
        int   pulses;
        int   pulse_at;
        seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int e = 0; e < 10; e++) drive_edge('0);
        pulses   = 0;
        pulse_at = -1;
        for (int e = 0; e < 17; e++) begin
            logic b;
            b = (e < 7) ? seq[e] : 1'b1;
            drive_edge({4'b0, b, 5'b0});
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL bounce e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[5] === 1'b1) begin
                pulses++;
                pulse_at = e;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 12) begin
            failures++;
            $display("FAIL bounce_count: pulses=%0d at edge %0d expected 1 at edge 12", pulses, pulse_at);
        end
    endtask

    task automatic test_simultaneous();
        int pulse_at;
        logic [W-1:0] bits1 [0:5];
        bits1 = '{10'h2A7, 10'h2A5, 10'h2A7, 10'h2A7, 10'h2A5, 10'h2A7};
        for (int e = 0; e < 10; e++) drive_edge('0);
        pulse_at = -1;
        for (int e = 0; e < 8; e++) begin
            drive_edge(10'h2A5);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL simul e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse === 10'h2A5 && pulse_at < 0) pulse_at = e;
        end
        checks++;
        if (pulse_at != 5) begin
            failures++;
            $display("FAIL simul_latency: pulse 2A5 at edge %0d expected 5", pulse_at);
        end
        for (int e = 0; e < 14; e++) begin
            drive_edge(e < 6 ? bits1[e] : 10'h2A5);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse || (debounced_out & 10'h3FD) !== 10'h2A5) begin
                failures++;
                $display("FAIL indep e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulse_at;
        for (int e = 0; e < 10; e++) drive_edge('0);
        for (int e = 0; e < 4; e++) drive_edge(10'h200);
        reset = 1'b1;
        model_reset();
        #1;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (debounced_out[9] !== 1'b0 || change_pulse !== '0) begin
                failures++;
                $display("FAIL reset_mid_hold e=%0d: out=%h pulse=%h expected bit9=0 pulse=000", e, debounced_out, change_pulse);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        pulse_at = -1;
        for (int e = 0; e < 10; e++) begin
            drive_edge(10'h200);
            checks++;
            if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL reset_mid e=%0d: out=%h exp=%h pulse=%h exp=%h", e, debounced_out, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[9] === 1'b1 && pulse_at < 0) pulse_at = e;
        end
        checks++;
        if (pulse_at != 5) begin
            failures++;
            $display("FAIL reset_mid_latency: bit9 pulse at edge %0d expected 5", pulse_at);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur;
        cur = debounced_out === m_out ? m_out : '0;
        for (int run = 0; run < 120; run++) begin
            int len;
            cur = cur ^ (W'($urandom) & W'($urandom));
            len = int'($urandom_range(1, 2 * N + 1));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                checks++;
                if (debounced_out !== RV || change_pulse !== '0) begin
                    failures++;
                    $display("FAIL random_reset run=%0d: out=%h pulse=%h expected out=%h pulse=000", run, debounced_out, change_pulse, RV);
                end
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            for (int e = 0; e < len; e++) begin
                drive_edge(cur);
                checks++;
                if (debounced_out !== m_out || change_pulse !== m_pulse) begin
                    failures++;
                    $display("FAIL random run=%0d e=%0d: out=%h exp=%h pulse=%h exp=%h", run, e, debounced_out, m_out, change_pulse, m_pulse);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
